spi_ram_ctrl: RTL and testbench

Parametrised command-driven single-port memory that sits behind the SPI slave's deserialiser. It decodes 2-bit opcodes on each received frame to set write/read pointers, write data and issue reads. Read data is returned through a valid/ready handshake so the SPI slave can apply backpressure while it serialises the previous byte. It is the generalised successor of the fixed 256x8 SPI RAM, adding width/depth parameters, handshake-held output, read-overflow reporting and optional pointer auto-increment.

---
 rtl/spi_ram_ctrl_if.sv | 21 ++
 rtl/spi_ram_ctrl.sv | 86 ++++++++
 tb/tb_spi_ram_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_ctrl_if.sv
// rtl/spi_ram_ctrl_if.sv - frame/read-data handshake bundle between the SPI slave and spi_ram_ctrl
interface spi_ram_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              rd_ovf;

  modport master (
    output din, rx_valid, tx_ready,
    input  dout, tx_valid, rd_ovf
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output dout, tx_valid, rd_ovf
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - opcode-driven single-port RAM with held read-data handshake
// Optional pointer auto-increment is enabled by defining RAM_AUTOINC_EN.
module spi_ram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;
  localparam logic [1:0] OP_READ      = 2'b11;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] dout_q;
  logic              tx_valid_q;
  logic              rd_ovf_q;

  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic              slot_free;
  logic              read_cmd;
  logic              do_read;
  logic              do_write;

  assign opcode    = bus.din[DATA_W+1:DATA_W];
  assign payload   = bus.din[DATA_W-1:0];
  // the slot is reusable in the same cycle its current word is being taken
  assign slot_free = !tx_valid_q || bus.tx_ready;
  assign read_cmd  = bus.rx_valid && (opcode == OP_READ);
  assign do_read   = read_cmd && slot_free;
  assign do_write  = bus.rx_valid && (opcode == OP_WRITE);

  always_ff @(posedge clk) begin
    if (rst_n && do_write) begin
      mem[wr_ptr] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      rd_ovf_q   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      rd_ovf_q <= read_cmd && !slot_free;

      if (do_read) begin
        dout_q     <= mem[rd_ptr];
        tx_valid_q <= 1'b1;
      end else if (tx_valid_q && bus.tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      if (bus.rx_valid && (opcode == OP_SET_WADDR)) begin
        wr_ptr <= payload[ADDR_W-1:0];
      end
`ifdef RAM_AUTOINC_EN
      else if (do_write) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
`endif

      if (bus.rx_valid && (opcode == OP_SET_RADDR)) begin
        rd_ptr <= payload[ADDR_W-1:0];
      end
`ifdef RAM_AUTOINC_EN
      else if (do_read) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
`endif
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.rd_ovf   = rd_ovf_q;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - randomized scoreboard bench for spi_ram_ctrl against a command-level model
module tb_spi_ram_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_ram_ctrl_if #(.DATA_W(DATA_W)) bus ();

  spi_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int tag;
    bit valid;
    bit ovf;
    bit rst;
  } status_t;

  status_t     st_q[$];
  logic [7:0]  data_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  m_mem [DEPTH];
  int          m_wp = 0;
  int          m_rp = 0;
  bit          m_pend = 0;
  bit          m_ovf = 0;

  always @(posedge clk) cyc++;

  // Drive one command for the coming edge and predict what that edge does.
  task automatic step(input bit rst, input bit rxv, input bit [1:0] op,
                      input bit [7:0] pl, input bit rdy);
    bit free;
    @(posedge clk);
    #1;
    rst_n        = !rst;
    bus.rx_valid = rxv;
    bus.din      = {op, pl};
    bus.tx_ready = rst ? 1'b0 : rdy;
    if (rst) begin
      m_pend = 0; m_ovf = 0; m_wp = 0; m_rp = 0;
      data_q.delete();
    end else begin
      free  = !m_pend || rdy;
      m_ovf = 0;
      if (m_pend && rdy) m_pend = 0;
      if (rxv) begin
        case (op)
          2'd0: m_wp = pl % DEPTH;
          2'd1: begin
            m_mem[m_wp] = pl;
            if (AUTOINC) m_wp = (m_wp + 1) % DEPTH;
          end
          2'd2: m_rp = pl % DEPTH;
          default: begin
            if (free) begin
              data_q.push_back(m_mem[m_rp]);
              m_pend = 1;
              if (AUTOINC) m_rp = (m_rp + 1) % DEPTH;
            end else begin
              m_ovf = 1;
            end
          end
        endcase
      end
    end
    st_q.push_back('{tag: cyc + 1, valid: m_pend, ovf: m_ovf, rst: rst});
  endtask

  task automatic cmd(input bit [1:0] op, input bit [7:0] pl, input bit rdy);
    step(1'b0, 1'b1, op, pl, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 2'd0, 8'h00, rdy);
  endtask

  initial begin
    status_t s;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (st_q.size() > 0 && st_q[0].tag == cyc) begin
        s = st_q.pop_front();
        checks++;
        if (bus.tx_valid !== s.valid) begin
          errors++;
          $display("FAIL tx_valid cyc=%0d got=%b exp=%b", cyc, bus.tx_valid, s.valid);
        end
        checks++;
        if (bus.rd_ovf !== s.ovf) begin
          errors++;
          $display("FAIL rd_ovf cyc=%0d got=%b exp=%b", cyc, bus.rd_ovf, s.ovf);
        end
        if (s.rst) begin
          checks++;
          if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout cyc=%0d got=%h exp=00", cyc, bus.dout);
          end
        end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transfer cyc=%0d got=%h exp=none", cyc, bus.dout);
        end else begin
          e = data_q.pop_front();
          if (bus.dout !== e) begin
            errors++;
            $display("FAIL read_data cyc=%0d got=%h exp=%h", cyc, bus.dout, e);
          end
        end
      end
    end
  end

  initial begin
    bus.din = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd3, 8'hFF, 1'b1);

    // every location gets a known value so reads never return X
    for (int a = 0; a < DEPTH; a++) begin
      cmd(2'd0, 8'(a), 1'b0);
      cmd(2'd1, 8'($urandom_range(0, 255)), 1'b0);
    end

    // basic write/read, consumed immediately
    cmd(2'd0, 8'h10, 1'b1); cmd(2'd1, 8'hA5, 1'b1);
    cmd(2'd2, 8'h10, 1'b1); cmd(2'd3, 8'h00, 1'b1);
    idle(1'b1); idle(1'b1);

    // backpressure: second READ dropped, then release
    cmd(2'd2, 8'h10, 1'b0); cmd(2'd3, 8'h00, 1'b0); cmd(2'd3, 8'h00, 1'b0);
    idle(1'b0); idle(1'b1); idle(1'b1);

    // READ in the same cycle as a transfer
    cmd(2'd0, 8'h11, 1'b0); cmd(2'd1, 8'h3C, 1'b0);
    cmd(2'd2, 8'h10, 1'b0); cmd(2'd3, 8'h00, 1'b0);
    cmd(2'd2, 8'h11, 1'b0); cmd(2'd3, 8'h00, 1'b1);
    idle(1'b0); idle(1'b1); idle(1'b1);

    // burst across the top of the address space
    cmd(2'd0, 8'hFE, 1'b1);
    cmd(2'd1, 8'h01, 1'b1); cmd(2'd1, 8'h02, 1'b1); cmd(2'd1, 8'h03, 1'b1);
    cmd(2'd2, 8'hFE, 1'b1);
    cmd(2'd3, 8'h00, 1'b1); cmd(2'd3, 8'h00, 1'b1); cmd(2'd3, 8'h00, 1'b1);
    idle(1'b1); idle(1'b1);

    // repeated writes/reads without re-addressing
    cmd(2'd0, 8'h20, 1'b1); cmd(2'd1, 8'h11, 1'b1); cmd(2'd1, 8'h22, 1'b1);
    cmd(2'd2, 8'h20, 1'b1); cmd(2'd3, 8'h00, 1'b1); cmd(2'd3, 8'h00, 1'b1);
    idle(1'b1); idle(1'b1);

    // reset with a pending read result; memory must survive
    cmd(2'd0, 8'h40, 1'b0); cmd(2'd1, 8'h5A, 1'b0);
    cmd(2'd2, 8'h40, 1'b0); cmd(2'd3, 8'h00, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b1, 2'd3, 8'h00, 1'b0);
    cmd(2'd2, 8'h40, 1'b1); cmd(2'd3, 8'h00, 1'b1);
    idle(1'b1); idle(1'b1);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 8,
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 4; i++) idle(1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (data_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", data_q.size(), st_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
